// File: rtl/stream_cipher_pkg.sv
// ---------------------------------------------------------------------------
// stream_cipher_pkg
// Shared types and defaults for the stream_decipher block:
//   byte_t   - 8-bit data byte
//   state_t  - control FSM states (IDLE / ACTIVE / DRAIN)
//   DEFAULT_MAX_LEN, DEFAULT_FIFO_DEPTH - default parameter values
// ---------------------------------------------------------------------------
package stream_cipher_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_MAX_LEN    = 16;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/cipher_fifo.sv
// ---------------------------------------------------------------------------
// cipher_fifo
// Synchronous FIFO holding plaintext bytes plus their end-of-message flag.
// Head entry is presented combinationally (first-word fall-through).
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   i_flush            - discard all entries (wins over push/pop)
//   i_push, i_data,
//   i_last             - write one entry (ignored when full)
//   i_pop              - remove head entry (ignored when empty)
//   o_data, o_last     - head entry, forced to zero while empty
//   o_empty, o_full    - occupancy flags
// DEPTH must be a power of two (2..16) so pointers wrap naturally.
// ---------------------------------------------------------------------------
module cipher_fifo
    import stream_cipher_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_flush,
    input  logic  i_push,
    input  byte_t i_data,
    input  logic  i_last,
    input  logic  i_pop,
    output byte_t o_data,
    output logic  o_last,
    output logic  o_empty,
    output logic  o_full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;

    logic          w_push;
    logic          w_pop;
    logic [8:0]    w_head;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));

    assign w_push  = i_push & ~o_full  & ~i_flush;
    assign w_pop   = i_pop  & ~o_empty & ~i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + (AW+1)'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - (AW+1)'(1);
        end
    end

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {i_last, i_data};
    end

    assign w_head = r_mem[r_rd];
    assign o_data = o_empty ? '0 : w_head[7:0];
    assign o_last = ~o_empty & w_head[8];

endmodule

// File: rtl/stream_decipher.sv
// ---------------------------------------------------------------------------
// stream_decipher
// Chained-XOR stream decipher: p = ct ^ chain (^ key), chain <- ct after
// every accepted byte, chain cleared on start. Plaintext is buffered in a
// cipher_fifo and drained on a valid/ready interface.
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   start                         - begin / restart (abort) a message
//   ct_data, ct_valid, ct_last,
//   ct_ready                      - ciphertext input handshake
//   pt_data, pt_valid, pt_last,
//   pt_ready                      - plaintext output handshake
//   busy                          - FSM not in IDLE
//   err_len                       - sticky: MAX_LEN bytes seen without ct_last
//   key (STREAM_DECIPHER_KEY_EN)  - per-message key, sampled on start
// Optional feature macro: STREAM_DECIPHER_KEY_EN (key port; key is 0x00 when
// undefined).
// ---------------------------------------------------------------------------
module stream_decipher
    import stream_cipher_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int unsigned MAX_LEN    = DEFAULT_MAX_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] ct_data,
    input  logic       ct_valid,
    input  logic       ct_last,
    output logic       ct_ready,
    output logic [7:0] pt_data,
    output logic       pt_valid,
    output logic       pt_last,
    input  logic       pt_ready,
    output logic       busy,
    output logic       err_len
`ifdef STREAM_DECIPHER_KEY_EN
  , input  logic [7:0] key
`endif
);

    localparam int unsigned CW = $clog2(MAX_LEN + 1);

    state_t        r_state;
    byte_t         r_chain;
    logic [CW-1:0] r_count;
    logic          r_err_len;
    byte_t         w_key;

    logic          w_accept;
    logic          w_at_max;
    logic          w_tag_last;
    byte_t         w_pt_byte;
    logic          w_fifo_empty;
    logic          w_fifo_full;

`ifdef STREAM_DECIPHER_KEY_EN
    byte_t r_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_key <= '0;
        else if (start) r_key <= key;
    end

    assign w_key = r_key;
`else
    assign w_key = '0;
`endif

    // start masks ready so an abort never accepts a byte in the same cycle;
    // full masks ready even when the consumer pops this cycle.
    assign ct_ready   = (r_state == ST_ACTIVE) & ~w_fifo_full & ~start;
    assign w_accept   = ct_ready & ct_valid;
    assign w_at_max   = (r_count == CW'(MAX_LEN - 1));
    assign w_tag_last = ct_last | w_at_max;
    assign w_pt_byte  = ct_data ^ r_chain ^ w_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_chain   <= '0;
            r_count   <= '0;
            r_err_len <= 1'b0;
        end else if (start) begin
            r_state   <= ST_ACTIVE;
            r_chain   <= '0;
            r_count   <= '0;
            r_err_len <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: ;
                ST_ACTIVE: begin
                    if (w_accept) begin
                        r_chain <= ct_data;
                        r_count <= r_count + CW'(1);
                        if (w_at_max && !ct_last) r_err_len <= 1'b1;
                        if (w_tag_last)           r_state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_fifo_empty) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    cipher_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (start),
        .i_push  (w_accept),
        .i_data  (w_pt_byte),
        .i_last  (w_tag_last),
        .i_pop   (pt_ready),
        .o_data  (pt_data),
        .o_last  (pt_last),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign pt_valid = ~w_fifo_empty;
    assign busy     = (r_state != ST_IDLE);
    assign err_len  = r_err_len;

endmodule

// File: tb/tb_stream_decipher.sv
// ---------------------------------------------------------------------------
// tb_stream_decipher
// Randomized and directed stimulus; a monitor holds a message-level model of
// the decipher (plaintext = ct ^ previous ct of the message ^ key) and a
// scoreboard queue of expected plaintext bytes.
// ---------------------------------------------------------------------------
module tb_stream_decipher;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXL  = 16;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic [7:0] ct_data  = '0;
    logic       ct_valid = 1'b0;
    logic       ct_last  = 1'b0;
    logic       pt_ready = 1'b0;
    logic       ct_ready;
    logic [7:0] pt_data;
    logic       pt_valid;
    logic       pt_last;
    logic       busy;
    logic       err_len;
    logic [7:0] key_val  = '0;

    stream_decipher #(
        .FIFO_DEPTH (DEPTH),
        .MAX_LEN    (MAXL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ct_data  (ct_data),
        .ct_valid (ct_valid),
        .ct_last  (ct_last),
        .ct_ready (ct_ready),
        .pt_data  (pt_data),
        .pt_valid (pt_valid),
        .pt_last  (pt_last),
        .pt_ready (pt_ready),
        .busy     (busy),
        .err_len  (err_len)
`ifdef STREAM_DECIPHER_KEY_EN
      , .key      (key_val)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard monitor ----------------
    // m_phase: 0 no message, 1 taking ciphertext, 2 waiting for drain
    int unsigned m_phase = 0;
    int unsigned m_nbytes = 0;
    logic [7:0]  m_prev = '0;
    logic [7:0]  m_key  = '0;
    bit          m_err  = 0;
    logic [8:0]  sb [$];

    always @(negedge clk) begin
        bit         e_rdy;
        bit         was_empty;
        bit         lst;
        if (!rst_n) begin
            chk("rst_ct_ready", ct_ready, 0);
            chk("rst_pt_valid", pt_valid, 0);
            chk("rst_pt_last",  pt_last,  0);
            chk("rst_pt_data",  pt_data,  0);
            chk("rst_busy",     busy,     0);
            chk("rst_err_len",  err_len,  0);
            sb.delete();
            m_phase = 0; m_nbytes = 0; m_prev = '0; m_err = 0;
        end else begin
            e_rdy = (m_phase == 1) && (sb.size() < DEPTH) && !start;
            chk("ct_ready", ct_ready, e_rdy);
            chk("pt_valid", pt_valid, sb.size() != 0);
            chk("busy",     busy,     m_phase != 0);
            chk("err_len",  err_len,  m_err);
            if (sb.size() != 0) begin
                chk("pt_data", pt_data, sb[0][7:0]);
                chk("pt_last", pt_last, sb[0][8]);
            end
            if (start) begin
                sb.delete();
                m_phase = 1; m_nbytes = 0; m_prev = '0; m_err = 0;
`ifdef STREAM_DECIPHER_KEY_EN
                m_key = key_val;
`else
                m_key = '0;
`endif
            end else begin
                was_empty = (sb.size() == 0);
                if (!was_empty && pt_ready) void'(sb.pop_front());
                if (e_rdy && ct_valid) begin
                    lst = ct_last || (m_nbytes + 1 == MAXL);
                    sb.push_back({lst, ct_data ^ m_prev ^ m_key});
                    if (!ct_last && (m_nbytes + 1 == MAXL)) m_err = 1;
                    m_prev = ct_data;
                    m_nbytes++;
                    if (lst) m_phase = 2;
                end else if (m_phase == 2 && was_empty) begin
                    m_phase = 0;
                end
            end
        end
    end

    // ---------------- consumer ready generator ----------------
    bit rnd_ready = 0;
    always @(posedge clk) begin
        #1;
        if (rnd_ready) pt_ready = ($urandom % 4) != 0;
    end

    // ---------------- driver tasks (enter/leave at posedge + 1) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic offer(input logic [7:0] d, input logic l, input int unsigned max_cyc,
                         output bit acc);
        ct_data = d; ct_last = l; ct_valid = 1'b1; acc = 0;
        for (int unsigned i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (ct_ready) begin
                acc = 1;
                tick();
                break;
            end
            tick();
        end
        ct_valid = 1'b0; ct_last = 1'b0;
    endtask

    task automatic send(input string name, input logic [7:0] d, input logic l);
        bit acc;
        offer(d, l, 100, acc);
        chk(name, acc, 1);
    endtask

    task automatic wait_idle(input int unsigned n);
        bit done = 0;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1;
                break;
            end
        end
        chk("drain_timeout", done, 1);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit acc;
        int unsigned len;
        bit aborted;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // "AB" message
        pt_ready = 1'b1;
        pulse_start();
        send("ab_b0", 8'h41, 1'b0);
        send("ab_b1", 8'h03, 1'b1);
        wait_idle(20);

        // back-pressure: 6 bytes against a 4-entry buffer
        pt_ready = 1'b0;
        pulse_start();
        fork
            begin
                for (int unsigned i = 0; i < 6; i++)
                    send("bp_accept", 8'(8'h10 + i), i == 5);
            end
            begin
                repeat (12) tick();
                pt_ready = 1'b1;
            end
        join
        wait_idle(40);

        // length overflow
        pulse_start();
        for (int unsigned i = 0; i < MAXL; i++) send("max_accept", 8'h00, 1'b0);
        offer(8'h00, 1'b0, 5, acc);
        chk("max_17th_rejected", acc, 0);
        wait_idle(40);
        chk("err_len_sticky", err_len, 1);
        pulse_start();
        chk("err_len_cleared", err_len, 0);
        send("after_err", 8'h5A, 1'b1);
        wait_idle(20);

        // abort with a same-cycle ciphertext handshake attempt
        pt_ready = 1'b0;
        pulse_start();
        send("abort_b0", 8'h11, 1'b0);
        send("abort_b1", 8'h22, 1'b0);
        start = 1'b1; ct_valid = 1'b1; ct_data = 8'h99; ct_last = 1'b0;
        tick();
        start = 1'b0; ct_valid = 1'b0;
        chk("abort_flushed", pt_valid, 0);
        pt_ready = 1'b1;
        send("abort_55", 8'h55, 1'b1);
        wait_idle(20);

        // reset mid-message
        pt_ready = 1'b0;
        pulse_start();
        send("rst_b0", 8'h31, 1'b0);
        send("rst_b1", 8'h32, 1'b0);
        send("rst_b2", 8'h33, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_pt_valid", pt_valid, 0);
        chk("async_rst_busy",     busy,     0);
        chk("async_rst_ct_ready", ct_ready, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        pt_ready = 1'b1;
        repeat (3) tick();
        pulse_start();
        send("post_rst", 8'h30, 1'b1);
        wait_idle(20);

`ifdef STREAM_DECIPHER_KEY_EN
        key_val = 8'hFF;
        pulse_start();
        send("key_b0", 8'h41, 1'b1);
        wait_idle(20);
`endif

        // randomized messages with random back-pressure, gaps and aborts
        rnd_ready = 1;
        for (int unsigned m = 0; m < 40; m++) begin
`ifdef STREAM_DECIPHER_KEY_EN
            key_val = 8'($urandom);
`endif
            pulse_start();
            len = $urandom_range(1, MAXL + 3);
            aborted = 0;
            for (int unsigned i = 0; i < len; i++) begin
                if ($urandom % 4 == 0) repeat ($urandom_range(1, 3)) tick();
                if ($urandom % 30 == 0) begin
                    pulse_start();
                    aborted = 1;
                    break;
                end
                if (i < MAXL) begin
                    send("rnd_accept", 8'($urandom), i == len - 1);
                end else begin
                    offer(8'($urandom), i == len - 1, 3, acc);
                    chk("rnd_over_rejected", acc, 0);
                end
            end
            if (!aborted) wait_idle(200);
        end
        rnd_ready = 0;
        pt_ready = 1'b1;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
